// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package     : regfile_pkg
// Description : Shared widths and loader state encoding for register_file
//               and regfile_burst_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Default geometry shared with register_file
  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 2;

  // Burst loader sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    DRAIN = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } loader_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_burst_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : regfile_burst_loader_if
// Description : Command, data stream, register-file port and status bundle
//               of the burst loader. The slave modport is the loader's view,
//               the master modport is the surrounding environment's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_burst_loader_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) ();

  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic              verify;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic [ADDR_W-1:0] rf_r_addr;
  logic [DATA_W-1:0] rf_r_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;
  logic              err;

  modport slave (
    input  start, base, len, verify, in_valid, in_data, rf_r_data,
    output in_ready, rf_w_en, rf_w_addr, rf_w_data, rf_r_addr,
           busy, done, checksum, err
  );

  modport master (
    output start, base, len, verify, in_valid, in_data, rf_r_data,
    input  in_ready, rf_w_en, rf_w_addr, rf_w_data, rf_r_addr,
           busy, done, checksum, err
  );

endinterface : regfile_burst_loader_if
`default_nettype wire

// File: rtl/mod_sum_acc.sv
`default_nettype none
// ============================================================================
// Module      : mod_sum_acc
// Description : Modulo-2^DATA_W running-sum accumulator with synchronous
//               clear (priority) and add enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_sum_acc
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [DATA_W-1:0] add_data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q;

  // Accumulate with natural wrap; clear wins over add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_q + add_data_i;
    end
  end

  assign sum_o = sum_q;

endmodule : mod_sum_acc
`default_nettype wire

// File: rtl/regfile_burst_loader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_burst_loader
// Description : Burst write sequencer for register_file. Writes a stream of
//               beats to consecutive wrapping addresses, optionally sweeps
//               them back through the read port and compares checksums.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_burst_loader
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_burst_loader_if.slave  bus
);

  localparam int              LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH   = LEN_W'(1 << ADDR_W);
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  loader_state_e     state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] rptr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              verify_q;
  logic              rf_w_en_q;
  logic [ADDR_W-1:0] rf_w_addr_q;
  logic [DATA_W-1:0] rf_w_data_q;
  logic [DATA_W-1:0] checksum_q;
  logic              err_q;

  logic [LEN_W-1:0]  len_sat;
  logic              start_acc;
  logic              beat;
  logic              last_cnt;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;

  logic              in_ready_c;
  logic              busy_c;
  logic              done_c;

  // Requests longer than the array collapse to one full sweep
  assign len_sat   = (bus.len > DEPTH) ? DEPTH : bus.len;
  assign start_acc = (state_q == IDLE) && bus.start;
  assign beat      = (state_q == WRITE) && bus.in_valid;
  assign last_cnt  = (cnt_q == CNT_ONE);

  // Write-side checksum; cleared on every accepted command so len==0 reports 0
  mod_sum_acc #(.DATA_W(DATA_W)) u_wsum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_acc),
    .add_en_i   (beat),
    .add_data_i (bus.in_data),
    .sum_o      (wsum)
  );

  // Read-back checksum; one combinational read sampled per READ cycle
  mod_sum_acc #(.DATA_W(DATA_W)) u_rsum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_acc || (state_q == DRAIN)),
    .add_en_i   (state_q == READ),
    .add_data_i (bus.rf_r_data),
    .sum_o      (rsum)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (len_sat == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (beat && last_cnt) begin
          state_d = verify_q ? DRAIN : DONE;
        end
      end
      DRAIN: state_d = READ;
      READ: begin
        if (last_cnt) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state_q)
      IDLE:    busy_c     = 1'b0;
      WRITE:   in_ready_c = 1'b1;
      DONE:    done_c     = 1'b1;
      default: ;
    endcase
  end

  // Pointers, counter, registered write port and completion results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      verify_q    <= 1'b0;
      rf_w_en_q   <= 1'b0;
      rf_w_addr_q <= '0;
      rf_w_data_q <= '0;
      checksum_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rf_w_en_q <= beat;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            base_q   <= bus.base;
            len_q    <= len_sat;
            verify_q <= bus.verify;
            wptr_q   <= bus.base;
            cnt_q    <= len_sat;
          end
        end
        WRITE: begin
          if (beat) begin
            rf_w_addr_q <= wptr_q;
            rf_w_data_q <= bus.in_data;
            wptr_q      <= wptr_q + ADDR_W'(1);
            cnt_q       <= cnt_q - CNT_ONE;
          end
        end
        DRAIN: begin
          rptr_q <= base_q;
          cnt_q  <= len_q;
        end
        READ: begin
          rptr_q <= rptr_q + ADDR_W'(1);
          cnt_q  <= cnt_q - CNT_ONE;
        end
        DONE: begin
          checksum_q <= wsum;
          err_q      <= verify_q && (rsum != wsum);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.rf_w_en   = rf_w_en_q;
  assign bus.rf_w_addr = rf_w_addr_q;
  assign bus.rf_w_data = rf_w_data_q;
  assign bus.rf_r_addr = rptr_q;
  assign bus.checksum  = checksum_q;
  assign bus.err       = err_q;

endmodule : regfile_burst_loader
`default_nettype wire

// File: tb/tb_regfile_burst_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_burst_loader
// Description : Scoreboard bench for regfile_burst_loader with a local
//               register-file model and a read-data override mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_burst_loader;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [7:0] ck;
    logic       err;
  } dn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  wr_t  exp_w[$];
  dn_t  exp_d[$];
  bit   pend = 1'b0;
  logic [7:0] pend_ck;
  logic       pend_err;

  logic [7:0] rf_mem [4];
  bit         force_en = 1'b0;
  logic [1:0] force_addr = 2'd0;
  logic [7:0] force_val = 8'd0;

  logic [7:0] bd [8];
  int         bg [8];

  regfile_burst_loader_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  regfile_burst_loader #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file stand-in: registered write, combinational read
  always @(posedge clk) begin
    if (bus.rf_w_en) rf_mem[bus.rf_w_addr] <= bus.rf_w_data;
  end

  assign bus.rf_r_data = (force_en && (bus.rf_r_addr == force_addr)) ?
                         force_val : rf_mem[bus.rf_r_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or done
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("checksum", {24'd0, bus.checksum}, {24'd0, pend_ck});
        chk("err", {31'd0, bus.err}, {31'd0, pend_err});
        pend = 1'b0;
      end
      if (bus.rf_w_en) begin
        if (exp_w.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = exp_w.pop_front();
          chk("w_addr", {30'd0, bus.rf_w_addr}, {30'd0, e.addr});
          chk("w_data", {24'd0, bus.rf_w_data}, {24'd0, e.data});
        end
      end
      if (bus.done) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          dn_t d;
          d = exp_d.pop_front();
          chk("done_cycle", cyc, d.cyc);
          pend     = 1'b1;
          pend_ck  = d.ck;
          pend_err = d.err;
        end
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    while ((exp_d.size() != 0 || pend) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) begin
      chk("done_timeout", 32'd1, 32'd0);
      exp_d.delete();
      exp_w.delete();
      pend = 1'b0;
    end
  endtask

  // One command plus its beats; expectations come from the burst rules
  task automatic run_burst(input logic [1:0] b, input int l, input bit v, input bit noise);
    int n;
    int e0;
    int edge_k;
    int acc;
    int wsum;
    int rsum;
    n = (l > 4) ? 4 : l;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.base   = b;
    bus.len    = l[2:0];
    bus.verify = v;
    @(negedge clk);
    e0 = cyc;
    bus.start  = 1'b0;
    bus.base   = 2'($urandom);
    bus.len    = 3'($urandom);
    bus.verify = 1'($urandom);

    edge_k = e0;
    wsum   = 0;
    rsum   = 0;
    for (int i = 0; i < n; i++) begin
      logic [1:0] a;
      a = 2'(int'(b) + i);
      edge_k += 1 + bg[i];
      exp_w.push_back('{a, bd[i]});
      wsum += int'(bd[i]);
      rsum += (force_en && a == force_addr) ? int'(force_val) : int'(bd[i]);
    end
    if (v && n > 0) edge_k += n + 1;
    exp_d.push_back('{edge_k, 8'(wsum), (v && (8'(rsum) != 8'(wsum)))});

    if (n == 0) chk("in_ready_len0", {31'd0, bus.in_ready}, 32'd0);

    acc = 0;
    for (int i = 0; i < l; i++) begin
      int g;
      g = (i < n) ? bg[i] : 0;
      for (int k = 0; k < g; k++) begin
        bus.in_valid = 1'b0;
        bus.start    = noise;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = bd[i];
      bus.start    = noise && (i < n);
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("beats_accepted", acc, n);
    wait_done();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.base     = 2'd0;
    bus.len      = 3'd0;
    bus.verify   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bd[i] = 8'd0;
      bg[i] = 0;
    end
    #3;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_w_en", {31'd0, bus.rf_w_en}, 32'd0);
    chk("rst_checksum", {24'd0, bus.checksum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep with read-back
    bd[0] = 8'd10; bd[1] = 8'd20; bd[2] = 8'd30; bd[3] = 8'd40;
    run_burst(2'd0, 4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] want;
      want = 8'(10 * (i + 1));
      chk("rf_readback", {24'd0, rf_mem[i]}, {24'd0, want});
    end

    // Wrapping burst with a two-cycle gap, checksum wraps to 0x02
    bd[0] = 8'hFF; bd[1] = 8'h01; bd[2] = 8'h02;
    bg[2] = 2;
    run_burst(2'd3, 3, 1'b0, 1'b0);
    bg[2] = 0;

    // Empty command
    run_burst(2'd2, 0, 1'b1, 1'b0);

    // Corrupted read-back on address 2
    bd[0] = 8'd1; bd[1] = 8'd2; bd[2] = 8'd3; bd[3] = 8'd4;
    force_en = 1'b1; force_addr = 2'd2; force_val = 8'h00;
    run_burst(2'd1, 4, 1'b1, 1'b0);
    force_en = 1'b0;

    // Asynchronous reset in the middle of a burst
    @(negedge clk);
    bus.start = 1'b1; bus.base = 2'd0; bus.len = 3'd4; bus.verify = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    exp_w.push_back('{2'd0, 8'h11});
    exp_w.push_back('{2'd1, 8'h22});
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    @(negedge clk);
    bus.in_data = 8'h22;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("arst_w_en", {31'd0, bus.rf_w_en}, 32'd0);
    chk("arst_w_addr", {30'd0, bus.rf_w_addr}, 32'd0);
    chk("arst_w_data", {24'd0, bus.rf_w_data}, 32'd0);
    chk("arst_r_addr", {30'd0, bus.rf_r_addr}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_checksum", {24'd0, bus.checksum}, 32'd0);
    chk("arst_err", {31'd0, bus.err}, 32'd0);
    exp_w.delete();
    exp_d.delete();
    pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Oversized length with start noise while busy
    for (int i = 0; i < 8; i++) bd[i] = 8'($urandom);
    run_burst(2'd2, 7, 1'b0, 1'b1);

    // Randomised bursts
    for (int r = 0; r < 25; r++) begin
      logic [1:0] b;
      int         l;
      bit         v;
      bit         nz;
      b  = 2'($urandom);
      l  = $urandom_range(0, 7);
      v  = 1'($urandom);
      nz = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
        bd[i] = 8'($urandom);
        bg[i] = (i < 4) ? $urandom_range(0, 2) : 0;
      end
      force_en   = ($urandom_range(0, 2) == 0);
      force_addr = 2'($urandom);
      force_val  = 8'($urandom);
      run_burst(b, l, v, nz);
      force_en = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("leftover_writes", exp_w.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_burst_loader
`default_nettype wire
